// File: rtl/output_port_arbiter.sv
// Round-robin scheduler for one output direction; winning flit is registered onto out one cycle after grant.
// Backpressure: grants stop while the downstream credit count is zero, and no request is popped during rst.
module output_port_arbiter #(
  parameter int                   M_IN      = 6,
  parameter int                   FLIT_SIZE = 82,
  parameter int                   ROUTE_LEN = 3,
  parameter logic [ROUTE_LEN-1:0] PORT_DIR  = ROUTE_LEN'(1),
  parameter int                   CREDITS   = 5,
  parameter int                   CREDIT_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [M_IN*FLIT_SIZE-1:0]   in,
  input  logic [M_IN*ROUTE_LEN-1:0]   route_in,
  input  logic [M_IN-1:0]             in_valid,
  output logic [M_IN-1:0]             in_avail,
  input  logic                        credit_in,
  output logic                        out_valid,
  output logic [FLIT_SIZE-1:0]        out,
  output logic [CREDIT_W-1:0]         credits,
  output logic                        credit_err
);

  localparam int PTR_W = (M_IN > 1) ? $clog2(M_IN) : 1;
  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDITS);

  logic [FLIT_SIZE-1:0] flits [M_IN];
  logic [M_IN-1:0]      req;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     next_ptr;
  logic                 found;
  logic                 grant;
  int                   idx;

  always_comb begin
    for (int i = 0; i < M_IN; i++) begin
      flits[i] = in[i*FLIT_SIZE +: FLIT_SIZE];
      req[i]   = in_valid[i] && (route_in[i*ROUTE_LEN +: ROUTE_LEN] == PORT_DIR);
    end
  end

  // First requester at or after ptr, wrapping modulo M_IN.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < M_IN; k++) begin
      idx = (int'(ptr) + k) % M_IN;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign grant    = found && (credits != '0) && !rst;
  assign next_ptr = (win == PTR_W'(M_IN - 1)) ? '0 : win + PTR_W'(1);

  always_comb begin
    in_avail = '0;
    if (grant) in_avail[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out        <= '0;
      credits    <= CREDIT_FULL;
      ptr        <= '0;
      credit_err <= 1'b0;
    end else begin
      out_valid <= grant;
      if (grant) begin
        out <= flits[win];
        ptr <= next_ptr;
      end
      // A grant and a returned credit in the same cycle cancel out.
      if (grant && !credit_in) begin
        credits <= credits - CREDIT_W'(1);
      end else if (credit_in && !grant) begin
        if (credits == CREDIT_FULL) credit_err <= 1'b1;
        else                        credits    <= credits + CREDIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: round-robin order, credit flow, route filtering and reset.
module tb_output_port_arbiter;

  localparam int M_IN = 6;
  localparam int FW   = 82;
  localparam int RL   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [M_IN*FW-1:0] in;
  logic [M_IN*RL-1:0] route_in;
  logic [M_IN-1:0]   in_valid;
  logic [M_IN-1:0]   in_avail;
  logic              credit_in;
  logic              out_valid;
  logic [FW-1:0]     out;
  logic [2:0]        credits;
  logic              credit_err;

  int checks = 0;
  int errors = 0;

  output_port_arbiter #(
    .M_IN(M_IN), .FLIT_SIZE(FW), .ROUTE_LEN(RL), .PORT_DIR(3'd1),
    .CREDITS(5), .CREDIT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .route_in(route_in), .in_valid(in_valid),
    .in_avail(in_avail), .credit_in(credit_in), .out_valid(out_valid),
    .out(out), .credits(credits), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] flit_of(input int i);
    logic [71:0] base;
    base = 72'h0123456789ABCDEF00;
    return {2'b10, 8'(i) + 8'h30, base ^ 72'(i * 37)};
  endfunction

  function automatic logic [M_IN-1:0] onehot(input int i);
    logic [M_IN-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    credit_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < M_IN; i++) begin
      in[i*FW +: FW]       = flit_of(i);
      route_in[i*RL +: RL] = 3'd1;
    end
    rst       = 1'b1;
    in_valid  = '1;
    credit_in = 1'b0;
    tick();
    tick();
    check("rst_in_avail", in_avail, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_credits", credits, 5);
    check("rst_credit_err", credit_err, 0);
    in_valid = '0;
    rst      = 1'b0;

    // Single requester on port 2
    in_valid = 6'b000100;
    settle();
    check("single_avail", in_avail, 6'b000100);
    tick();
    in_valid = 6'b111111;
    check("single_out", out, flit_of(2));
    check("single_out_valid", out_valid, 1);
    check("single_credits", credits, 4);
    settle();
    check("single_next_ptr3", in_avail, 6'b001000);
    in_valid = '0;
    tick();
    check("single_idle_valid", out_valid, 0);
    check("single_hold_out", out, flit_of(2));

    // All six requesting with a credit returned every cycle
    do_reset();
    in_valid  = '1;
    credit_in = 1'b1;
    for (int k = 0; k < 7; k++) begin
      settle();
      check("rr_avail", in_avail, onehot(k % M_IN));
      tick();
      check("rr_out", out, flit_of(k % M_IN));
      check("rr_valid", out_valid, 1);
      check("rr_credits", credits, 5);
    end
    check("rr_no_err", credit_err, 0);

    // Ports 0 and 3 drain all credits, then stall until a credit returns
    do_reset();
    in_valid = 6'b001001;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("drain_avail", in_avail, (k % 2 == 0) ? 6'b000001 : 6'b001000);
      tick();
      check("drain_out", out, flit_of((k % 2 == 0) ? 0 : 3));
      check("drain_credits", credits, 4 - k);
    end
    settle();
    check("blocked_avail", in_avail, 0);
    tick();
    check("blocked_valid", out_valid, 0);
    check("blocked_credits", credits, 0);
    check("blocked_hold_out", out, flit_of(0));
    credit_in = 1'b1;
    settle();
    check("credit_turn_avail", in_avail, 0);
    tick();
    credit_in = 1'b0;
    check("credit_turn_credits", credits, 1);
    check("credit_turn_valid", out_valid, 0);
    settle();
    check("resume_avail", in_avail, 6'b001000);
    tick();
    check("resume_out", out, flit_of(3));
    check("resume_valid", out_valid, 1);
    check("resume_credits", credits, 0);

    // Route filter: port 1 targets another direction
    do_reset();
    route_in[1*RL +: RL] = 3'd3;
    in_valid = 6'b000010;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("filter_avail", in_avail, 0);
      tick();
      check("filter_valid", out_valid, 0);
    end
    check("filter_credits", credits, 5);
    route_in[1*RL +: RL] = 3'd1;

    // Simultaneous grant and credit at credits=1, then overflow
    do_reset();
    in_valid = 6'b000001;
    for (int k = 0; k < 4; k++) tick();
    check("sim_pre_credits", credits, 1);
    credit_in = 1'b1;
    tick();
    check("sim_credits", credits, 1);
    check("sim_valid", out_valid, 1);
    in_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    check("refill_credits", credits, 5);
    check("refill_no_err", credit_err, 0);
    tick();
    credit_in = 1'b0;
    check("ovf_credits", credits, 5);
    check("ovf_err", credit_err, 1);
    for (int k = 0; k < 3; k++) tick();
    check("ovf_err_sticky", credit_err, 1);

    // Reset mid-stream with credits=2 and sticky error set
    in_valid = '1;
    for (int k = 0; k < 3; k++) tick();
    check("mid_pre_credits", credits, 2);
    check("mid_pre_err", credit_err, 1);
    rst = 1'b1;
    settle();
    check("mid_rst_avail", in_avail, 0);
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_credits", credits, 5);
    check("mid_rst_err", credit_err, 0);
    check("mid_rst_out", out, 0);
    rst = 1'b0;
    settle();
    check("post_rst_avail", in_avail, 6'b000001);
    tick();
    check("post_rst_out", out, flit_of(0));
    check("post_rst_credits", credits, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
